mac_sched: RTL

- Shares one fixed-point multiply-accumulate datapath (fp multiply, then add) between NREQ requesters.
- Each requester owns a private accumulator register.
- A round-robin arbiter grants at most one operation per cycle into a 2-stage pipeline.
- Lets several NISC cores or DSP channels time-multiplex a single multiplier instead of instantiating one each.

---
 rtl/mac_pkg.sv | 50 +++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mac_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared widths, stage-1 record and fixed-point multiply for mac_sched.
// Build with MAC_SAT_EN defined to saturate the shifted product instead of truncating it.
package mac_pkg;

   localparam int MAC_N    = 8;
   localparam int MAC_F    = 4;
   localparam int MAC_NMAX = 16;
   localparam int MAC_IDW  = 4;

   // Operands are kept sign-extended to MAC_NMAX so one record serves any n up to MAC_NMAX.
   typedef struct packed {
      logic [MAC_NMAX-1:0] a;
      logic [MAC_NMAX-1:0] b;
      logic                clr;
      logic [MAC_IDW-1:0]  id;
      logic                valid;
   } mac_s1_t;

   function automatic logic [MAC_NMAX-1:0] fxp_mul(
      input logic [MAC_NMAX-1:0] a,
      input logic [MAC_NMAX-1:0] b,
      input int                  n = MAC_N,
      input int                  f = MAC_F
   );
      logic signed [2*MAC_NMAX-1:0] w_p;
      logic signed [2*MAC_NMAX-1:0] w_s;
      logic        [MAC_NMAX-1:0]   w_r;
`ifdef MAC_SAT_EN
      logic signed [2*MAC_NMAX-1:0] w_hi;
      logic signed [2*MAC_NMAX-1:0] w_lo;
`endif
      w_p = (2*MAC_NMAX)'($signed(a)) * (2*MAC_NMAX)'($signed(b));
      w_s = w_p >>> f;
`ifdef MAC_SAT_EN
      w_hi = ((2*MAC_NMAX)'(1) <<< (n - 1)) - (2*MAC_NMAX)'(1);
      w_lo = -w_hi - (2*MAC_NMAX)'(1);
      if (w_s > w_hi) begin
         w_r = w_hi[MAC_NMAX-1:0];
      end else if (w_s < w_lo) begin
         w_r = w_lo[MAC_NMAX-1:0];
      end else begin
         w_r = w_s[MAC_NMAX-1:0];
      end
`else
      w_r = w_s[MAC_NMAX-1:0];
`endif
      return w_r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer, pointer moves past the winner.
// Zero latency; the pointer only moves on advance, so an unserved request keeps its place.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] w_idx;
   logic [IDW-1:0] w_gid;
   logic           w_found;

   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_gid   = r_ptr;
      w_idx   = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = IDW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_gid   = w_idx;
         end
      end
      if (w_found) begin
         grant = NREQ'(1) << w_gid;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_ptr <= '0;
      end else if (advance && w_found) begin
         r_ptr <= IDW'((int'(w_gid) + 1) % NREQ);
      end
   end

endmodule

// File: rtl/mac_sched.sv
// Shared fixed-point MAC time-multiplexed over NREQ requesters with private accumulators (MAC_SAT_EN: saturating).
// Latency: handshake at edge k gives rsp_valid/rsp_data after edge k+2; one op per cycle, responses never stall.
module mac_sched
   import mac_pkg::*;
#(
   parameter int n    = MAC_N,
   parameter int F    = MAC_F,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*n-1:0] req_a,
   input  logic [NREQ*n-1:0] req_b,
   input  logic [NREQ-1:0]   req_clr,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [NREQ*n-1:0] rsp_data
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]         w_grant;
   logic [NREQ-1:0]         w_ready;
   logic [IDW-1:0]          w_gid;
   logic [n-1:0]            w_a;
   logic [n-1:0]            w_b;
   logic                    w_clr;

   mac_s1_t                 r_s1;
   logic [n-1:0]            r_s2_prod;
   logic                    r_s2_clr;
   logic [IDW-1:0]          r_s2_id;
   logic                    r_s2_vld;

   logic [NREQ-1:0][n-1:0]  r_acc;
   logic [NREQ-1:0]         r_rsp_vld;
   logic [n-1:0]            w_base;
   logic [n-1:0]            w_acc_nxt;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_arb (
      .clk     (clk),
      .nReset  (nReset),
      .req     (req_valid),
      .advance (|w_ready),
      .grant   (w_grant)
   );

   // Masking with nReset keeps ready low while reset is held, even though the grant is combinational.
   assign w_ready = w_grant & {NREQ{nReset}};

   always_comb begin
      w_gid = '0;
      w_a   = '0;
      w_b   = '0;
      w_clr = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_grant[k]) begin
            w_gid = IDW'(k);
            w_a   = req_a[k*n +: n];
            w_b   = req_b[k*n +: n];
            w_clr = req_clr[k];
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_s1 <= '0;
      end else begin
         r_s1.valid <= |w_ready;
         if (|w_ready) begin
            r_s1.a   <= MAC_NMAX'($signed(w_a));
            r_s1.b   <= MAC_NMAX'($signed(w_b));
            r_s1.clr <= w_clr;
            r_s1.id  <= MAC_IDW'(w_gid);
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_s2_vld  <= 1'b0;
         r_s2_prod <= '0;
         r_s2_clr  <= 1'b0;
         r_s2_id   <= '0;
      end else begin
         r_s2_vld <= r_s1.valid;
         if (r_s1.valid) begin
            r_s2_prod <= n'(fxp_mul(r_s1.a, r_s1.b, n, F));
            r_s2_clr  <= r_s1.clr;
            r_s2_id   <= IDW'(r_s1.id);
         end
      end
   end

   // Only this stage reads or writes acc, so back-to-back ops on one id chain without forwarding.
   assign w_base = r_s2_clr ? '0 : r_acc[r_s2_id];

`ifdef MAC_SAT_EN
   logic [n:0] w_sum;

   always_comb begin
      w_sum = {w_base[n-1], w_base} + {r_s2_prod[n-1], r_s2_prod};
      if (w_sum[n] != w_sum[n-1]) begin
         w_acc_nxt = w_sum[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      end else begin
         w_acc_nxt = w_sum[n-1:0];
      end
   end
`else
   assign w_acc_nxt = w_base + r_s2_prod;
`endif

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_acc     <= '0;
         r_rsp_vld <= '0;
      end else begin
         r_rsp_vld <= r_s2_vld ? (NREQ'(1) << r_s2_id) : '0;
         if (r_s2_vld) begin
            r_acc[r_s2_id] <= w_acc_nxt;
         end
      end
   end

   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_vld;
   assign rsp_data  = r_acc;

endmodule
